// File: rtl/mips_ctl_pkg.sv
// mips_ctl_pkg: shared opcodes, instruction fields, FSM states and op classes for the MIPS control sequencer
package mips_ctl_pkg;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam logic [5:0] OP_HALT = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_BEQ  = 6'd8;
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD_IR = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC    = 4'd4,
        S_MEM     = 4'd5,
        S_WB      = 4'd6,
        S_HALT    = 4'd7,
        S_ERR     = 4'd8
    } state_t;
    typedef enum logic [2:0] {
        C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_HALT, C_ILLEGAL
    } op_class_t;
endpackage

// File: rtl/mips_ctl_decode.sv
// mips_ctl_decode: maps an opcode to its execution class
module mips_ctl_decode
    import mips_ctl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls
);
    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_OR, OP_AND: cls = C_RTYPE;
            OP_ADDI:                       cls = C_IMM;
            OP_LW:                         cls = C_LOAD;
            OP_SW:                         cls = C_STORE;
            OP_BEQ:                        cls = C_BRANCH;
            OP_HALT:                       cls = C_HALT;
            default:                       cls = C_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mips_ctrl_seq.sv
// mips_ctrl_seq: multi-cycle control sequencer issuing one-cycle datapath strobes
module mips_ctrl_seq
    import mips_ctl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic [31:0]      inst,
    input  logic             beq_eq,
    output logic             ic_read,
    output logic             ir_ld,
    output logic             pc_incr,
    output logic             pc_ld,
    output logic             reg_read,
    output logic             reg_write,
    output logic             dc_read,
    output logic             dc_write,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_count,
    output logic [3:0]       cur_state
);
    state_t    state, nxt;
    op_class_t dec_cls, cls;
    logic      retire;
    logic      unused_inst;

    assign unused_inst = ^inst[OPC_LSB-1:0];

    mips_ctl_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode(inst[OPC_LSB +: OPC_W]),
        .cls   (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cls        <= C_ILLEGAL;
            inst_count <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE)
                cls <= dec_cls;
            if (retire && inst_count != '1)
                inst_count <= inst_count + CNT_W'(1);
        end
    end

    // Class is latched at the end of DECODE, so later states never look at the IR again
    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            S_IDLE:    nxt = start ? S_FETCH : S_IDLE;
            S_FETCH:   nxt = S_LOAD_IR;
            S_LOAD_IR: nxt = S_DECODE;
            S_DECODE:  nxt = dec_cls == C_HALT ? S_HALT : dec_cls == C_ILLEGAL ? S_ERR : S_EXEC;
            S_EXEC: begin
                retire = cls == C_BRANCH;
                nxt    = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                retire = cls == C_STORE;
                nxt    = S_WB;
            end
            S_WB:      retire = 1'b1;
            S_HALT:    nxt = S_HALT;
            default:   nxt = S_ERR;
        endcase
        if (retire)
            nxt = step_mode ? S_IDLE : S_FETCH;
    end

    always_comb begin
        ic_read   = state == S_FETCH;
        ir_ld     = state == S_LOAD_IR;
        pc_incr   = state == S_LOAD_IR;
        reg_read  = state == S_DECODE;
        pc_ld     = state == S_EXEC && cls == C_BRANCH && beq_eq;
        dc_read   = state == S_MEM && cls == C_LOAD;
        dc_write  = state == S_MEM && cls == C_STORE;
        reg_write = state == S_WB;
        busy      = !(state inside {S_IDLE, S_HALT, S_ERR});
        halted    = state == S_HALT;
        illegal   = state == S_ERR;
        cur_state = state;
    end
endmodule

// File: tb/tb_mips_ctrl_seq.sv
// tb_mips_ctrl_seq: directed self-checking bench for the control sequencer
module tb_mips_ctrl_seq;
    localparam logic [7:0] NO = 8'h00, IC = 8'h80, IRPC = 8'h60, PCLD = 8'h10;
    localparam logic [7:0] RR = 8'h08, RW = 8'h04, DR = 8'h02, DW = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n, start, step_mode, beq_eq;
    logic [31:0] inst;
    logic        ic_read, ir_ld, pc_incr, pc_ld, reg_read, reg_write, dc_read, dc_write;
    logic        busy, halted, illegal;
    logic [15:0] inst_count;
    logic [3:0]  cur_state;
    logic [7:0]  strb;
    int          total = 0, bad = 0;

    assign strb = {ic_read, ir_ld, pc_incr, pc_ld, reg_read, reg_write, dc_read, dc_write};

    always #5 clk = ~clk;

    mips_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .inst(inst),
        .beq_eq(beq_eq), .ic_read(ic_read), .ir_ld(ir_ld), .pc_incr(pc_incr), .pc_ld(pc_ld),
        .reg_read(reg_read), .reg_write(reg_write), .dc_read(dc_read), .dc_write(dc_write),
        .busy(busy), .halted(halted), .illegal(illegal), .inst_count(inst_count),
        .cur_state(cur_state)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the sample point of cycle 1 (FETCH)
    task automatic launch(input logic [5:0] opc, input logic eq, input logic step);
        inst      = {opc, 26'h0};
        beq_eq    = eq;
        step_mode = step;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (strb !== NO) begin bad++; $display("FAIL reset_strb got=%h exp=%h", strb, NO); end
        total++; if (cur_state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", cur_state); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", inst_count); end
        total++; if ({busy, halted, illegal} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, halted, illegal}); end
        repeat (3) @(negedge clk);
        total++; if (cur_state !== 4'd0) begin bad++; $display("FAIL reset_hold got=%0d exp=0", cur_state); end
    endtask

    task automatic test_add();
        logic [7:0] e [6] = '{IC, IRPC, RR, NO, RW, IC};
        do_reset();
        launch(6'd1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (strb !== e[i]) begin bad++; $display("FAIL add_strb c%0d got=%h exp=%h", i + 1, strb, e[i]); end
            if (i == 1) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", busy); end
            end
            if (i == 4) begin
                total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL add_cnt_wb got=%0d exp=0", inst_count); end
            end
        end
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL add_cnt got=%0d exp=1", inst_count); end
        total++; if (cur_state !== 4'd1) begin bad++; $display("FAIL add_refetch got=%0d exp=1", cur_state); end
    endtask

    task automatic test_lw();
        logic [7:0] e [7] = '{IC, IRPC, RR, NO, DR, RW, IC};
        do_reset();
        launch(6'd5, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (strb !== e[i]) begin bad++; $display("FAIL lw_strb c%0d got=%h exp=%h", i + 1, strb, e[i]); end
        end
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL lw_cnt got=%0d exp=1", inst_count); end
    endtask

    task automatic test_beq();
        logic [7:0] e [9] = '{IC, IRPC, RR, PCLD, IC, IRPC, RR, NO, IC};
        do_reset();
        launch(6'd8, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 4) beq_eq = 1'b0;
            total++; if (strb !== e[i]) begin bad++; $display("FAIL beq_strb c%0d got=%h exp=%h", i + 1, strb, e[i]); end
            if (i == 4) begin
                total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL beq_cnt1 got=%0d exp=1", inst_count); end
            end
        end
        total++; if (inst_count !== 16'd2) begin bad++; $display("FAIL beq_cnt2 got=%0d exp=2", inst_count); end
    endtask

    task automatic test_step();
        logic [7:0] ea [6] = '{IC, IRPC, RR, NO, RW, NO};
        logic [7:0] es [6] = '{IC, IRPC, RR, NO, DW, NO};
        do_reset();
        launch(6'd1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (strb !== ea[i]) begin bad++; $display("FAIL step_add c%0d got=%h exp=%h", i + 1, strb, ea[i]); end
        end
        total++; if (cur_state !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL step_idle1 got=%0d/%b exp=0/0", cur_state, busy); end
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL step_cnt1 got=%0d exp=1", inst_count); end
        repeat (2) @(negedge clk);
        total++; if (cur_state !== 4'd0) begin bad++; $display("FAIL step_wait got=%0d exp=0", cur_state); end
        launch(6'd6, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (strb !== es[i]) begin bad++; $display("FAIL step_sw c%0d got=%h exp=%h", i + 1, strb, es[i]); end
        end
        total++; if (cur_state !== 4'd0) begin bad++; $display("FAIL step_idle2 got=%0d exp=0", cur_state); end
        total++; if (inst_count !== 16'd2) begin bad++; $display("FAIL step_cnt2 got=%0d exp=2", inst_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch(6'd1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL mid_wb got=%b exp=1", reg_write); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (strb !== NO) begin bad++; $display("FAIL mid_strb got=%h exp=%h", strb, NO); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (cur_state !== 4'd0) begin bad++; $display("FAIL mid_state got=%0d exp=0", cur_state); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", inst_count); end
    endtask

    task automatic test_halt();
        do_reset();
        launch(6'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++; if ({halted, busy, illegal} !== 3'b100) begin bad++; $display("FAIL halt_flags got=%b exp=100", {halted, busy, illegal}); end
        total++; if (cur_state !== 4'd7) begin bad++; $display("FAIL halt_state got=%0d exp=7", cur_state); end
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        total++; if (cur_state !== 4'd7 || strb !== NO) begin bad++; $display("FAIL halt_sticky got=%0d/%h exp=7/00", cur_state, strb); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL halt_cnt got=%0d exp=0", inst_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        launch(6'd63, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++; if ({illegal, busy, halted} !== 3'b100) begin bad++; $display("FAIL ill_flags got=%b exp=100", {illegal, busy, halted}); end
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        total++; if (cur_state !== 4'd8 || strb !== NO) begin bad++; $display("FAIL ill_sticky got=%0d/%h exp=8/00", cur_state, strb); end
        do_reset();
        total++; if (illegal !== 1'b0 || cur_state !== 4'd0) begin bad++; $display("FAIL ill_clear got=%b/%0d exp=0/0", illegal, cur_state); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; beq_eq = 1'b0; inst = '0;
        test_reset();
        test_add();
        test_lw();
        test_beq();
        test_step();
        test_reset_mid();
        test_halt();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
